regfile_arbiter: RTL
====================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 13, the register-file word width.
REQ-002 The block SHALL have parameter ADDR_W, default 3, the register-file address width (8 entries).
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 8, the cycles the display requester may wait before it is forced a grant.
REQ-004 Port Clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port Reset, input, 1: asynchronous, active-high reset.
REQ-006 Ports reqGame / reqDisp, input, 1 each: access requests from the game FSM and the score-display scanner.
REQ-007 Ports gameWrite input 1, gameAddr input ADDR_W, gameData input DATA_W: the game requester's write strobe, address and write data.
REQ-008 Port dispAddr, input, ADDR_W: display read address (read-only requester).
REQ-009 Ports grantGame / grantDisp, output, 1 each: the current owner of the register-file ports.
REQ-010 Ports rfWriteEnable output 1, rfWriteAddress output ADDR_W, rfWriteData output DATA_W: the register-file write port.
REQ-011 Ports rfReadAddress output ADDR_W, rfReadData input DATA_W: the register-file read port Q.
REQ-012 Ports gameReadData / dispReadData, output, DATA_W each: registered read results.
REQ-013 Port dispValid, output, 1: pulses when dispReadData is updated.
REQ-014 Port busy, output, 1: high in any non-IDLE state.

Function
REQ-015 The FSM SHALL have states IDLE, GAME and DISP, with grantGame = (state==GAME) and grantDisp = (state==DISP) as Moore outputs.
REQ-016 From IDLE, a request SHALL move the FSM to the requester's state on the next edge, so the grant appears one cycle after the request.
REQ-017 When both requests are present in IDLE, GAME SHALL win unless the starve flag is set, in which case DISP wins.
REQ-018 A grant SHALL hold while its request stays high, except as in REQ-021.
REQ-019 When the owner drops its request, the FSM SHALL move on the next edge to the other state if that requester is requesting, else to IDLE.
REQ-020 The starve counter SHALL increment each cycle reqDisp=1 and grantDisp=0, clear on grantDisp, and saturate at STARVE_LIMIT; the starve flag is counter==STARVE_LIMIT.
REQ-021 In GAME with the starve flag set and reqDisp=1, the FSM SHALL move to DISP on the next edge and keep DISP at least one cycle, even if reqGame stays high.
REQ-022 rfWriteEnable SHALL be combinational grantGame & gameWrite, with rfWriteAddress=gameAddr and rfWriteData=gameData.
REQ-023 rfWriteEnable SHALL be 0 in IDLE and DISP, and the display requester SHALL never write.
REQ-024 rfReadAddress SHALL be gameAddr in GAME, dispAddr in DISP and 0 in IDLE.
REQ-025 rfReadData SHALL be captured on the edge that ends each granted cycle, into gameReadData (GAME) or dispReadData (DISP); read latency is 1 cycle.
REQ-026 dispValid SHALL be high for exactly the cycle after each DISP cycle.
REQ-027 The read-data register of the non-owner SHALL hold its value.
REQ-028 A request dropped in the same cycle it is granted SHALL still complete that one granted cycle, and its read data SHALL be captured.

Reset
REQ-029 Reset asserted SHALL force immediately (not on a clock edge): state=IDLE, both grants 0, busy 0, dispValid 0, starve counter 0, and both read-data registers 0.
REQ-030 Reset asserted during a write cycle SHALL drop rfWriteEnable combinationally, so no partial write occurs after reset.

Configuration
REQ-031 With macro REGFILE_ARB_FAIR_EN defined, the starve counter and REQ-017/020/021 preemption SHALL be compiled in.
REQ-032 Without REGFILE_ARB_FAIR_EN, arbitration SHALL be strict game priority, with no counter logic and the starve flag tied 0.

Structure
REQ-033 A shared package regarb_pkg SHALL hold the state enum (IDLE=2'b00, GAME=2'b01, DISP=2'b10) and the DATA_W/ADDR_W/STARVE_LIMIT defaults.
REQ-034 The starve counter SHALL be a separate sub-module, starve_counter (inc, clr, saturate, flag output), instantiated only under REGFILE_ARB_FAIR_EN.

Verification
REQ-035 Scenario: reqGame=1, gameWrite=1, gameAddr=3, gameData=13'd250 from IDLE -> grantGame at cycle 1, and rfWriteEnable=1 with address 3 and data 250 at cycle 1.
REQ-036 Scenario: reqGame and reqDisp rise together in IDLE -> GAME granted; after reqGame drops, DISP is granted on the next edge.
REQ-037 Scenario (FAIR_EN): reqGame held high and reqDisp high for 8 cycles -> DISP forced after the counter reaches 8, and dispReadData equals the entry at dispAddr with a one-cycle dispValid pulse.
REQ-038 Scenario (no FAIR_EN): the same stimulus as REQ-037 -> grantDisp stays 0 while reqGame stays high.
REQ-039 Scenario: Reset pulsed mid-GAME write -> grants, rfWriteEnable and busy go 0 without a clock edge, and read registers read 0.
REQ-040 Scenario: reqDisp one-cycle pulse with dispAddr=0 holding 13'd4 -> dispReadData=4 with one dispValid pulse, and the FSM returns to IDLE.

Source files
------------

// File: rtl/regfile_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regarb_pkg
// Shared definitions for the score register-file arbiter:
//   - arbState_t       : arbiter FSM state encoding (IDLE / GAME / DISP)
//   - DEF_DATA_W       : default register-file word width
//   - DEF_ADDR_W       : default register-file address width (8 entries)
//   - DEF_STARVE_LIMIT : default cycles the display may wait before it is
//                        forced a grant (used only with REGFILE_ARB_FAIR_EN)
//   - countWidth()     : bits needed to hold a saturating count up to a limit
// ---------------------------------------------------------------------------
package regarb_pkg;

  localparam int DEF_DATA_W       = 13;
  localparam int DEF_ADDR_W       = 3;
  localparam int DEF_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GAME = 2'b01,
    DISP = 2'b10
  } arbState_t;

  // A counter that saturates at 'limit' must be able to hold 'limit' itself,
  // hence limit+1 distinct values.
  function automatic int countWidth(input int limit);
    int w;
    w = $clog2(limit + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_arbiter_if
// Bundles the requester, register-file and read-result signals around the
// arbiter.
//   master modport : the environment (game FSM, display scanner, register
//                    file Q port) -- drives requests and rfReadData
//   slave modport  : the arbiter -- drives grants, register-file ports,
//                    registered read results, dispValid and busy
// Signals:
//   reqGame, reqDisp          access requests
//   gameWrite/gameAddr/gameData  game write strobe, address, data
//   dispAddr                  display read address (display never writes)
//   grantGame, grantDisp      current owner of the register-file ports
//   rfWriteEnable/rfWriteAddress/rfWriteData  register-file write port
//   rfReadAddress, rfReadData register-file read port
//   gameReadData, dispReadData registered read results
//   dispValid                 one-cycle pulse when dispReadData updates
//   busy                      arbiter is not idle
// ---------------------------------------------------------------------------
interface regfile_arbiter_if
  import regarb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              reqGame;
  logic              reqDisp;
  logic              gameWrite;
  logic [ADDR_W-1:0] gameAddr;
  logic [DATA_W-1:0] gameData;
  logic [ADDR_W-1:0] dispAddr;

  logic              grantGame;
  logic              grantDisp;

  logic              rfWriteEnable;
  logic [ADDR_W-1:0] rfWriteAddress;
  logic [DATA_W-1:0] rfWriteData;
  logic [ADDR_W-1:0] rfReadAddress;
  logic [DATA_W-1:0] rfReadData;

  logic [DATA_W-1:0] gameReadData;
  logic [DATA_W-1:0] dispReadData;
  logic              dispValid;
  logic              busy;

  modport master (
    output reqGame, reqDisp, gameWrite, gameAddr, gameData, dispAddr,
    output rfReadData,
    input  grantGame, grantDisp,
    input  rfWriteEnable, rfWriteAddress, rfWriteData, rfReadAddress,
    input  gameReadData, dispReadData, dispValid, busy
  );

  modport slave (
    input  reqGame, reqDisp, gameWrite, gameAddr, gameData, dispAddr,
    input  rfReadData,
    output grantGame, grantDisp,
    output rfWriteEnable, rfWriteAddress, rfWriteData, rfReadAddress,
    output gameReadData, dispReadData, dispValid, busy
  );

endinterface

// File: rtl/regfile_arbiter_starve_counter.sv
// ---------------------------------------------------------------------------
// starve_counter
// Saturating wait counter for the display requester. Only compiled when the
// fairness option REGFILE_ARB_FAIR_EN is defined; the default build has no
// starvation logic at all.
// Ports:
//   Clock  rising-edge clock
//   Reset  asynchronous active-high reset (count -> 0)
//   inc    count one waiting cycle
//   clr    display has the bus; restart the count (wins over inc)
//   flag   count has reached LIMIT
// ---------------------------------------------------------------------------
`ifdef REGFILE_ARB_FAIR_EN
module starve_counter
  import regarb_pkg::*;
#(
  parameter int LIMIT = DEF_STARVE_LIMIT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic inc,
  input  logic clr,
  output logic flag
);

  localparam int             CNT_W = countWidth(LIMIT);
  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count;

  // Counts waiting cycles and parks at MAX_COUNT so the flag stays up until
  // the display is actually served.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_COUNT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign flag = (count == MAX_COUNT);

endmodule
`endif

// File: rtl/regfile_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_arbiter
// Two-requester arbiter for the score register file. The game FSM may read
// and write; the display scanner only reads. Ownership is a three-state Moore
// FSM (IDLE / GAME / DISP). The owner's address drives the read port, and
// the read word is registered into the owner's result register on the edge
// that ends each granted cycle (one-cycle read latency).
//
// Default build: strict game priority.
// With REGFILE_ARB_FAIR_EN defined: a starve_counter tracks how long the
// display has waited; once it reaches STARVE_LIMIT the display wins ties in
// IDLE and preempts an ongoing game grant.
//
// Parameters: DATA_W, ADDR_W, STARVE_LIMIT
// Ports:
//   Clock  rising-edge clock
//   Reset  asynchronous active-high reset
//   bus    regfile_arbiter_if.slave (requests, grants, register-file ports,
//          read results, dispValid, busy)
// ---------------------------------------------------------------------------
module regfile_arbiter
  import regarb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic             Clock,
  input  logic             Reset,
  regfile_arbiter_if.slave bus
);

  arbState_t         state;
  arbState_t         nextState;
  logic              starveFlag;
  logic [DATA_W-1:0] gameReadReg;
  logic [DATA_W-1:0] dispReadReg;
  logic              dispValidReg;
  logic [ADDR_W-1:0] readAddress;

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. A starving display beats a requesting game both in
  // IDLE and mid-grant; otherwise the game always has priority.
  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE: begin
        if (bus.reqDisp && (starveFlag || !bus.reqGame)) begin
          nextState = DISP;
        end else if (bus.reqGame) begin
          nextState = GAME;
        end else begin
          nextState = IDLE;
        end
      end
      GAME: begin
        if (starveFlag && bus.reqDisp) begin
          nextState = DISP;
        end else if (bus.reqGame) begin
          nextState = GAME;
        end else if (bus.reqDisp) begin
          nextState = DISP;
        end else begin
          nextState = IDLE;
        end
      end
      DISP: begin
        if (bus.reqDisp) begin
          nextState = DISP;
        end else if (bus.reqGame) begin
          nextState = GAME;
        end else begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

`ifdef REGFILE_ARB_FAIR_EN
  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) uStarveCounter (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (bus.reqDisp && (state != DISP)),
    .clr   (state == DISP),
    .flag  (starveFlag)
  );
`else
  logic unusedStarveLimit;
  assign unusedStarveLimit = ^STARVE_LIMIT;
  assign starveFlag        = 1'b0;
`endif

  // Read port address follows the owner; parked at 0 when idle.
  always_comb begin
    readAddress = '0;
    case (state)
      GAME:    readAddress = bus.gameAddr;
      DISP:    readAddress = bus.dispAddr;
      default: readAddress = '0;
    endcase
  end

  // Read-result capture at the end of each granted cycle; the non-owner's
  // register holds. dispValid marks the cycle after every DISP cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      gameReadReg  <= '0;
      dispReadReg  <= '0;
      dispValidReg <= 1'b0;
    end else begin
      dispValidReg <= (state == DISP);
      if (state == GAME) begin
        gameReadReg <= bus.rfReadData;
      end
      if (state == DISP) begin
        dispReadReg <= bus.rfReadData;
      end
    end
  end

  assign bus.grantGame      = (state == GAME);
  assign bus.grantDisp      = (state == DISP);
  assign bus.busy           = (state != IDLE);

  // Reset is folded in so a write strobe can never outlive a reset assertion,
  // even for the delta before the state register clears.
  assign bus.rfWriteEnable  = (state == GAME) && bus.gameWrite && !Reset;
  assign bus.rfWriteAddress = bus.gameAddr;
  assign bus.rfWriteData    = bus.gameData;
  assign bus.rfReadAddress  = readAddress;

  assign bus.gameReadData   = gameReadReg;
  assign bus.dispReadData   = dispReadReg;
  assign bus.dispValid      = dispValidReg;

endmodule
